and_n_sweep: RTL

AND_N_SWEEP -- requirements
Module: and_n_sweep

---
 rtl/and_n_sweep.sv | 131 +++++++++++++
 1 files changed

// File: rtl/and_n_sweep.sv
// Exhaustive sweep tester for an external N-input AND/NAND/OR/NOR gate.
// Drives every input vector, samples the gate after a settle window, and records mismatches.
module and_n_sweep #(
  parameter int N      = 3,
  parameter int SETTLE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic         dut_y,
  output logic [N-1:0] x,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [N:0]   err_cnt,
  output logic [N-1:0] fail_vec,
  output logic         fail_valid
);

  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_s;
  logic [CW-1:0] cnt_r;
  logic [1:0]    mode_r;
  logic          mismatch_s;
  logic [N:0]    err_next_s;

  function automatic logic gate_expect(input logic [1:0] m, input logic [N-1:0] v);
    logic y;
    case (m)
      2'd0:    y = &v;
      2'd1:    y = ~&v;
      2'd2:    y = |v;
      2'd3:    y = ~|v;
      default: y = 1'b0;
    endcase
    return y;
  endfunction

  // Next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = DRIVE;
        else       state_s = IDLE;
      end
      DRIVE: begin
        if (cnt_r == CNT_LAST) state_s = SAMPLE;
        else                   state_s = DRIVE;
      end
      SAMPLE: begin
        if (&x) state_s = DONE;
        else    state_s = DRIVE;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Compare the gate against the latched function; dut_y is only looked at in SAMPLE
  always_comb begin
    mismatch_s = 1'b0;
    if (state_r == SAMPLE) begin
      mismatch_s = (dut_y != gate_expect(mode_r, x));
    end else begin
      mismatch_s = 1'b0;
    end
    err_next_s = err_cnt + {{N{1'b0}}, mismatch_s};
  end

  // State, vector and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      cnt_r      <= {CW{1'b0}};
      mode_r     <= 2'd0;
      x          <= {N{1'b0}};
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= {(N+1){1'b0}};
      fail_vec   <= {N{1'b0}};
      fail_valid <= 1'b0;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == DRIVE) || (state_s == SAMPLE);
      done    <= (state_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            mode_r     <= mode;
            err_cnt    <= {(N+1){1'b0}};
            fail_vec   <= {N{1'b0}};
            fail_valid <= 1'b0;
            pass       <= 1'b0;
            x          <= {N{1'b0}};
            cnt_r      <= {CW{1'b0}};
          end
        end
        DRIVE: begin
          if (cnt_r == CNT_LAST) cnt_r <= {CW{1'b0}};
          else                   cnt_r <= cnt_r + CW'(1'b1);
        end
        SAMPLE: begin
          err_cnt <= err_next_s;
          if (mismatch_s && !fail_valid) begin
            fail_vec   <= x;
            fail_valid <= 1'b1;
          end
          // pass is resolved here so it is already valid during the done pulse
          if (!(&x)) x    <= x + N'(1'b1);
          else       pass <= (err_next_s == {(N+1){1'b0}});
        end
        DONE:    pass <= pass;
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule
